// File: rtl/div_ctrl.sv
// Sequencing controller between the EX stage and the radix-2 divider.
// Launches divides, stalls EX while they run, and holds the result for a one-cycle HI/LO write.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req,
    input  logic        div_sign,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        stall_other,
    output logic        stall_div,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] dv_a,
    output logic [31:0] dv_b,
    output logic        dv_sign,
    output logic        dv_opn_valid,
    output logic        dv_rst,
    input  logic        dv_res_valid,
    output logic        dv_res_ready,
    input  logic [63:0] dv_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        accept;
    logic        launch;
    logic        res_load;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        sign_q;

    // Handshake: dv_opn_valid is a single-cycle start strobe that the divider
    // always takes; dv_res_valid is a single-cycle result strobe that is only
    // honoured while dv_res_ready is high (BUSY), and never when flush is high.
    assign accept = div_req & ~flush & ~rst;

    always_comb begin
        state_nxt    = state;
        launch       = 1'b0;
        res_load     = 1'b0;
        res_hi       = dv_result[63:32];
        res_lo       = dv_result[31:0];
        hilo_we      = 1'b0;
        stall_div    = 1'b0;
        dv_res_ready = 1'b0;

        case (state)
            IDLE: begin
                stall_div = accept;
                if (accept) begin
                    if (src_b == 32'd0) begin
                        // Divide-by-zero is answered locally; the divider stays idle.
                        res_load  = 1'b1;
                        res_hi    = src_a;
                        res_lo    = 32'hFFFF_FFFF;
                        state_nxt = DONE;
                    end else begin
                        launch    = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_div    = accept;
                dv_res_ready = ~rst;
                if (dv_res_valid && !flush) begin
                    res_load  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // A div_req seen here is the instruction already being finished.
                hilo_we = ~stall_other & ~flush & ~rst;
                if (hilo_we) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (flush) begin
            state_nxt = IDLE;
            res_load  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            hi_o   <= 32'd0;
            lo_o   <= 32'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            sign_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (res_load) begin
                hi_o <= res_hi;
                lo_o <= res_lo;
            end
            if (launch) begin
                a_q    <= src_a;
                b_q    <= src_b;
                sign_q <= div_sign;
            end
        end
    end

    // Operands come straight from EX in the launch cycle and are held afterwards.
    assign dv_opn_valid = launch;
    assign dv_a         = launch ? src_a : a_q;
    assign dv_b         = launch ? src_b : b_q;
    assign dv_sign      = launch ? div_sign : sign_q;
    assign dv_rst       = rst | flush;

endmodule
